frame_serializer: RTL and testbench
===================================

FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameters SHALL be: WORD_W, default 16, channel word width; NUM_CH, default 8, words per frame; POP_HOLDOFF, default 4, read_clk cycles after a pop before fifo_ready is trusted again.
REQ-002 Ports SHALL be:
- read_clk  in  1  sole clock; same domain as the FIFO read side.
- reset_n  in  1  synchronous reset, active-low.
- enable  in  1  permit capture of new frames.
- chan_mask  in  NUM_CH  channel enable; bit i selects frame word i.
- fifo_ready  in  1  FIFO frame-available flag; frame data is valid while high.
- frame_data_in  in  NUM_CH*WORD_W  look-ahead head frame; word i = bits [16i+15:16i].
- frame_pop  out  1  one-cycle pulse that advances the FIFO read pointer.
- m_data  out  WORD_W  output word.
- m_chan  out  3  channel index of m_data.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  marks the last selected word of a frame.
- busy  out  1  high when not in IDLE.
- frame_count  out  16  frames popped since reset; wraps.

Function
REQ-003 The FSM SHALL have three states: IDLE, CAPTURE, SEND.
REQ-004 IDLE -> CAPTURE SHALL occur when enable=1, fifo_ready=1 and holdoff_cnt=0, all in the same cycle.
REQ-005 In CAPTURE, for one cycle:
- register frame_data_in into frame_reg.
- register chan_mask into mask_reg.
- assert frame_pop=1.
- load holdoff_cnt with POP_HOLDOFF.
- increment frame_count (mod 2^16).
REQ-006 CAPTURE -> SEND SHALL occur if mask_reg != 0; otherwise CAPTURE -> IDLE, the frame is discarded and no word is emitted.
REQ-007 In SEND, m_valid SHALL be 1 and m_data/m_chan SHALL present the lowest-index word still pending in mask_reg.
- m_data, m_chan and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-008 A word SHALL be accepted on a cycle with m_valid=1 and m_ready=1.
- On acceptance, its mask_reg bit is cleared.
- The next pending word is presented in the following cycle; zero bubble cycles between words.
REQ-009 m_last SHALL be 1 exactly when the presented word is the only bit remaining set in mask_reg.
- Acceptance of that word SHALL return the FSM to IDLE with m_valid=0 in the next cycle.
REQ-010 Latency: first m_valid SHALL rise 2 cycles after the IDLE cycle in which the REQ-004 condition holds.
REQ-011 holdoff_cnt SHALL decrement once per cycle while nonzero, independent of state.
- IDLE SHALL ignore fifo_ready while holdoff_cnt != 0. This covers CDC latency of the FIFO flag.
REQ-012 frame_pop SHALL never be asserted outside CAPTURE. At most one pop per captured frame.
REQ-013 Deasserting enable mid-frame SHALL NOT abort SEND. It only blocks the next capture.
REQ-014 Changes to chan_mask after CAPTURE SHALL NOT affect the frame in flight.
REQ-015 fifo_ready falling during SEND SHALL have no effect on the frame in flight.
REQ-016 busy SHALL equal (state != IDLE).

Reset
REQ-017 On read_clk with reset_n=0, the block SHALL:
- set state=IDLE.
- clear frame_pop, m_valid and m_last to 0.
- clear m_data, m_chan, frame_reg and mask_reg to 0.
- clear holdoff_cnt and frame_count to 0.
REQ-018 Reset asserted mid-SEND SHALL drop the remaining words with no further pop. The FSM returns to IDLE.

Structure
REQ-019 The shared package SHALL hold WORD_W, NUM_CH, FRAME_W (= NUM_CH*WORD_W) and the FSM state enum.
REQ-020 Lowest-set-bit selection SHALL be one combinational sub-module, chan_mask_scan.
- Inputs: mask.
- Outputs: index[2:0], any, single.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Full frame: chan_mask=8'hFF, frame words 0..7 = 16'h1000..16'h1007, m_ready=1 -> one frame_pop; m_data 1000..1007 on consecutive cycles; m_chan 0..7; m_last only on 1007; frame_count=1.
- Sparse mask: chan_mask=8'b0010_0100, words 2=AAAA and 5=BBBB -> exactly two words (chan 2 AAAA, then chan 5 BBBB with m_last=1).
- Backpressure: m_ready toggling 1,0,0,1 -> each word held stable until accepted; no word lost or duplicated.
- Zero mask: chan_mask=0 with fifo_ready=1 -> frame_pop pulses, m_valid stays 0, frame_count increments.
- Holdoff: fifo_ready held at 1 continuously with POP_HOLDOFF=4 and a single-word mask -> consecutive frame_pop pulses at least 5 cycles apart.
- Reset mid-SEND: reset_n=0 after 3 of 8 words -> next cycle m_valid=0, busy=0, frame_count=0, no frame_pop.

Source files
------------

// File: rtl/frame_serializer_pkg.sv
// Shared widths and FSM state type for the frame serializer.
package frame_serializer_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned FRAME_W = NUM_CH * WORD_W;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StSend
  } state_e;

endpackage

// File: rtl/chan_mask_scan.sv
// Lowest-set-bit finder over a channel mask; also flags any-set and exactly-one-set.
module chan_mask_scan #(
  parameter int unsigned NUM_CH = 8
) (
  input  logic [NUM_CH-1:0] mask,
  output logic [2:0]        index,
  output logic              any,
  output logic              single
);

  // Scan downward so the lowest set bit is the last writer.
  always_comb begin
    index = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask[i]) index = 3'(i);
    end
  end

  assign any    = |mask;
  assign single = any && ((mask & (mask - NUM_CH'(1))) == '0);

endmodule

// File: rtl/frame_serializer.sv
// Pops one frame from a look-ahead FIFO and streams its selected words, lowest channel first.
module frame_serializer #(
  parameter int unsigned WORD_W      = frame_serializer_pkg::WORD_W,
  parameter int unsigned NUM_CH      = frame_serializer_pkg::NUM_CH,
  parameter int unsigned POP_HOLDOFF = 4
) (
  input  logic                     read_clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        chan_mask,
  input  logic                     fifo_ready,
  input  logic [NUM_CH*WORD_W-1:0] frame_data_in,
  output logic                     frame_pop,
  output logic [WORD_W-1:0]        m_data,
  output logic [2:0]               m_chan,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy,
  output logic [15:0]              frame_count
);
  import frame_serializer_pkg::*;

  localparam int unsigned HoldW = (POP_HOLDOFF > 0) ? $clog2(POP_HOLDOFF + 1) : 1;

  state_e                     state;
  logic [NUM_CH*WORD_W-1:0]   frame_reg;
  logic [NUM_CH*WORD_W-1:0]   frame_sel;
  logic [NUM_CH-1:0]          mask_reg;
  logic [NUM_CH-1:0]          mask_nxt;
  logic [HoldW-1:0]           holdoff_cnt;
  logic [2:0]                 scan_index;
  logic                       scan_any;
  logic                       scan_single;
  logic                       accept;

  assign accept = m_valid && m_ready;
  assign busy   = (state != StIdle);

  // Mask/frame as they will be after this edge; the scan of it yields the next word to present.
  always_comb begin
    mask_nxt  = mask_reg;
    frame_sel = frame_reg;
    if (state == StCapture) begin
      mask_nxt  = chan_mask;
      frame_sel = frame_data_in;
    end else if (accept) begin
      mask_nxt = mask_reg & ~(NUM_CH'(1) << m_chan);
    end
  end

  chan_mask_scan #(
    .NUM_CH (NUM_CH)
  ) u_scan (
    .mask   (mask_nxt),
    .index  (scan_index),
    .any    (scan_any),
    .single (scan_single)
  );

  always_ff @(posedge read_clk) begin
    if (!reset_n) begin
      state       <= StIdle;
      frame_pop   <= 1'b0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      m_chan      <= '0;
      frame_reg   <= '0;
      mask_reg    <= '0;
      holdoff_cnt <= '0;
      frame_count <= '0;
    end else begin
      frame_pop <= 1'b0;
      if (holdoff_cnt != '0) holdoff_cnt <= holdoff_cnt - HoldW'(1);
      case (state)
        StIdle: begin
          if (enable && fifo_ready && (holdoff_cnt == '0)) begin
            state     <= StCapture;
            frame_pop <= 1'b1;
          end
        end
        StCapture: begin
          frame_reg   <= frame_data_in;
          mask_reg    <= chan_mask;
          holdoff_cnt <= HoldW'(POP_HOLDOFF);
          frame_count <= frame_count + 16'd1;
          if (scan_any) begin
            state   <= StSend;
            m_valid <= 1'b1;
            m_data  <= frame_sel[WORD_W*32'(scan_index) +: WORD_W];
            m_chan  <= scan_index;
            m_last  <= scan_single;
          end else begin
            state <= StIdle;
          end
        end
        StSend: begin
          if (accept) begin
            mask_reg <= mask_nxt;
            if (scan_any) begin
              m_data <= frame_sel[WORD_W*32'(scan_index) +: WORD_W];
              m_chan <= scan_index;
              m_last <= scan_single;
            end else begin
              state   <= StIdle;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Randomized + directed bench: a FIFO model feeds frames, a scoreboard checks the word stream.
module tb_frame_serializer;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned NUM_CH      = 8;
  localparam int unsigned FRAME_W     = WORD_W * NUM_CH;
  localparam int unsigned POP_HOLDOFF = 4;

  logic               read_clk;
  logic               reset_n;
  logic               enable;
  logic [NUM_CH-1:0]  chan_mask;
  logic               fifo_ready;
  logic [FRAME_W-1:0] frame_data_in;
  logic               frame_pop;
  logic [WORD_W-1:0]  m_data;
  logic [2:0]         m_chan;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;
  logic               busy;
  logic [15:0]        frame_count;

  frame_serializer #(
    .WORD_W      (WORD_W),
    .NUM_CH      (NUM_CH),
    .POP_HOLDOFF (POP_HOLDOFF)
  ) dut (
    .read_clk      (read_clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .chan_mask     (chan_mask),
    .fifo_ready    (fifo_ready),
    .frame_data_in (frame_data_in),
    .frame_pop     (frame_pop),
    .m_data        (m_data),
    .m_chan        (m_chan),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .busy          (busy),
    .frame_count   (frame_count)
  );

  initial begin
    read_clk = 1'b0;
    forever #5 read_clk = ~read_clk;
  end

  typedef struct {
    logic [2:0]        ch;
    logic [WORD_W-1:0] data;
    logic              last;
  } word_t;

  logic [FRAME_W-1:0] fifo_d[$];
  logic [NUM_CH-1:0]  fifo_m[$];
  word_t              exp_q[$];

  int   n_pass = 0;
  int   n_checks = 0;
  int   cyc = 0;
  int   last_pop_cyc = -1;
  int   pops = 0;
  int   accepted = 0;
  int   frames_total = 0;
  int   first_valid_cyc = -1;
  int   rdy_mode = 0;
  int   rp = 0;
  bit   pop_pending = 1'b0;
  bit   expect_valid = 1'b0;
  bit   hide = 1'b0;
  bit   lat_armed = 1'b0;
  logic [3:0] bp_pat = 4'b1001;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic load_frame(input logic [FRAME_W-1:0] d, input logic [NUM_CH-1:0] m);
    fifo_d.push_back(d);
    fifo_m.push_back(m);
    frames_total++;
  endtask

  // Expected words of a frame: its selected channels in ascending order, last one flagged.
  task automatic expand_frame(input logic [FRAME_W-1:0] d, input logic [NUM_CH-1:0] m);
    int top = -1;
    for (int i = 0; i < int'(NUM_CH); i++) if (m[i]) top = i;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (m[i]) begin
        word_t w;
        w.ch   = 3'(i);
        w.data = d[i*WORD_W +: WORD_W];
        w.last = (i == top);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic sample_phase();
    @(negedge read_clk);
    cyc++;
    if (frame_pop) begin
      check_eq("pop_has_frame", 32'(fifo_d.size() != 0), 32'd1);
      if (last_pop_cyc >= 0) check_eq("pop_gap_min5", 32'((cyc - last_pop_cyc) >= 5), 32'd1);
      last_pop_cyc = cyc;
      pops++;
      if (fifo_d.size() != 0) begin
        expand_frame(fifo_d[0], fifo_m[0]);
        pop_pending = 1'b1;
      end
    end
    if (expect_valid) check_eq("no_bubble", 32'(m_valid), 32'd1);
    expect_valid = 1'b0;
    if (m_valid) begin
      check_eq("busy_in_send", 32'(busy), 32'd1);
      if (lat_armed) begin
        first_valid_cyc = cyc;
        lat_armed = 1'b0;
      end
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", 32'(m_valid), 32'd0);
      end else begin
        check_eq("m_chan", 32'(m_chan), 32'(exp_q[0].ch));
        check_eq("m_data", 32'(m_data), 32'(exp_q[0].data));
        check_eq("m_last", 32'(m_last), 32'(exp_q[0].last));
        if (m_ready) begin
          if (!exp_q[0].last) expect_valid = 1'b1;
          exp_q.delete(0);
          accepted++;
        end
      end
    end
  endtask

  task automatic drive_phase();
    @(posedge read_clk);
    #1;
    if (pop_pending) begin
      fifo_d.delete(0);
      fifo_m.delete(0);
      pop_pending = 1'b0;
    end
    fifo_ready = (fifo_d.size() != 0) && !hide;
    if (fifo_d.size() != 0) begin
      frame_data_in = fifo_d[0];
      chan_mask     = fifo_m[0];
    end else begin
      frame_data_in = {$urandom, $urandom, $urandom, $urandom};
      chan_mask     = NUM_CH'($urandom);
    end
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: begin
        m_ready = bp_pat[rp];
        rp = (rp + 1) % 4;
      end
      2: m_ready = ($urandom_range(0, 9) < 7);
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic tick();
    sample_phase();
    drive_phase();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    enable = 1'b1;
    hide = 1'b0;
    if (rdy_mode == 3) rdy_mode = 0;
    while (n < budget && (fifo_d.size() != 0 || exp_q.size() != 0 || pop_pending || busy
                          || frame_pop)) begin
      tick();
      n++;
    end
    check_eq({tag, "_drained"}, 32'(fifo_d.size() + exp_q.size()), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_frame_count"}, 32'(frame_count), 32'(16'(frames_total)));
  endtask

  function automatic logic [FRAME_W-1:0] rand_frame();
    logic [FRAME_W-1:0] f;
    for (int i = 0; i < int'(NUM_CH); i++) f[i*WORD_W +: WORD_W] = WORD_W'($urandom);
    return f;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_W-1:0] f;
    int pops0;
    int acc0;
    int t0;
    int n;

    reset_n = 1'b0;
    enable = 1'b0;
    chan_mask = '0;
    fifo_ready = 1'b0;
    frame_data_in = '0;
    m_ready = 1'b0;

    repeat (3) tick();
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_frame_pop", 32'(frame_pop), 32'd0);
    check_eq("rst_m_last", 32'(m_last), 32'd0);
    check_eq("rst_m_data", 32'(m_data), 32'd0);
    check_eq("rst_m_chan", 32'(m_chan), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_count", 32'(frame_count), 32'd0);
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (2) tick();

    // Full frame with first-word latency.
    rdy_mode = 0;
    for (int i = 0; i < int'(NUM_CH); i++) f[i*WORD_W +: WORD_W] = 16'h1000 + 16'(i);
    pops0 = pops;
    load_frame(f, 8'hFF);
    lat_armed = 1'b1;
    tick();
    t0 = cyc + 1;
    drain("full", 100);
    check_eq("full_pop_latency", 32'(last_pop_cyc - t0), 32'd1);
    check_eq("full_valid_latency", 32'(first_valid_cyc - t0), 32'd2);
    check_eq("full_pops", 32'(pops - pops0), 32'd1);

    // Sparse mask.
    f = rand_frame();
    f[2*WORD_W +: WORD_W] = 16'hAAAA;
    f[5*WORD_W +: WORD_W] = 16'hBBBB;
    acc0 = accepted;
    load_frame(f, 8'b0010_0100);
    drain("sparse", 100);
    check_eq("sparse_words", 32'(accepted - acc0), 32'd2);

    // Backpressure 1,0,0,1.
    rdy_mode = 1;
    rp = 0;
    acc0 = accepted;
    load_frame(rand_frame(), 8'hFF);
    drain("bp", 200);
    check_eq("bp_words", 32'(accepted - acc0), 32'd8);

    // Zero mask.
    rdy_mode = 0;
    pops0 = pops;
    load_frame(rand_frame(), 8'h00);
    drain("zero", 100);
    check_eq("zero_pops", 32'(pops - pops0), 32'd1);

    // Holdoff with continuous fifo_ready and single-word frames.
    pops0 = pops;
    for (int k = 0; k < 4; k++) load_frame(rand_frame(), NUM_CH'(1) << $urandom_range(0, 7));
    drain("holdoff", 200);
    check_eq("holdoff_pops", 32'(pops - pops0), 32'd4);

    // Randomized traffic with enable/fifo_ready flicker and random backpressure.
    rdy_mode = 2;
    acc0 = accepted;
    n = 0;
    for (int k = 0; k < 40; ) begin
      if ($urandom_range(0, 3) == 0) begin
        load_frame(rand_frame(), ($urandom_range(0, 7) == 0) ? '0 : NUM_CH'($urandom));
        k++;
      end
      enable = ($urandom_range(0, 4) != 0);
      hide = ($urandom_range(0, 5) == 0);
      tick();
    end
    drain("rand", 4000);

    // Reset in the middle of a frame.
    rdy_mode = 0;
    load_frame(rand_frame(), 8'hFF);
    acc0 = accepted;
    n = 0;
    while (n < 50 && (accepted - acc0) < 3) begin
      tick();
      n++;
    end
    check_eq("midrst_reached_3", 32'(accepted - acc0), 32'd3);
    reset_n = 1'b0;
    m_ready = 1'b0;
    rdy_mode = 3;
    sample_phase();
    drive_phase();
    reset_n = 1'b1;
    exp_q.delete();
    fifo_d.delete();
    fifo_m.delete();
    pop_pending = 1'b0;
    expect_valid = 1'b0;
    frames_total = 0;
    last_pop_cyc = -1;
    sample_phase();
    check_eq("midrst_m_valid", 32'(m_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_frame_count", 32'(frame_count), 32'd0);
    check_eq("midrst_frame_pop", 32'(frame_pop), 32'd0);
    drive_phase();
    pops0 = pops;
    repeat (10) tick();
    check_eq("midrst_no_pop", 32'(pops - pops0), 32'd0);
    rdy_mode = 0;
    load_frame(rand_frame(), 8'b1000_0001);
    drain("recover", 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
